div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle integer divider in the EX stage, directly downstream of the main decoder.
- Consumes decoded DIV/DIVU operations and produces {HI=remainder, LO=quotient} for the hi/lo register file.
- Raises a stall request while it computes so the pipeline holds the divide instruction in EX.
- Restoring radix-2 algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width in bits; quotient and remainder are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request a divide; sampled only in IDLE
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- dividend  input  WIDTH  rs operand; sampled with start
- divisor  input  WIDTH  rt operand; sampled with start
- annul  input  1  cancel the current/requested operation (exception flush)
- stall_req  output  1  combinational: (state==IDLE & start & ~annul) | state==BUSY
- result_valid  output  1  registered; high for exactly one cycle when a result is ready
- result  output  2*WIDTH  registered {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, result_valid=0, result=0, iteration counter=0, internal operand registers=0. Reset during BUSY abandons the operation; no result_valid follows.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and annul=0 at edge E0: latch the operands, the signed_div flag and the operand signs.
  - In signed mode, latch the magnitudes |dividend| and |divisor|; otherwise latch the raw values.
  - If divisor==0: go to DONE and load result={dividend, all-ones}.
  - Otherwise: go to BUSY with count=0 and partial remainder=0.
  - start=1 with annul=1: ignored, stay in IDLE.
- BUSY:
  - Each edge E1..E32 performs one iteration: shift {rem, quo} left by 1 with the next dividend MSB, trial-subtract the divisor, keep the difference if it is non-negative, and set the quotient bit accordingly.
  - Count increments once per iteration.
  - On the WIDTH-th iteration edge, apply sign fixup and register result, then go to DONE.
  - start is ignored while BUSY.
- Sign fixup (signed_div=1 only):
  - Quotient is negated when sign(dividend) XOR sign(divisor).
  - Remainder is negated when the dividend is negative.
  - Remainder sign always equals the dividend sign.
  - -2^(WIDTH-1) / -1 yields quotient 0x80000000 and remainder 0. No overflow flag.
- DONE: result_valid=1 for this single cycle, then IDLE on the next edge. A new start can therefore be sampled at the earliest on the cycle after DONE.
- Latency:
  - Nonzero divisor: result_valid is high in the cycle after edge E(WIDTH), i.e. 32 edges after the start edge.
  - Zero divisor: result_valid is high in the cycle after E0.
- annul:
  - In BUSY: next edge returns to IDLE; result and result_valid are not updated.
  - In DONE: result_valid is still high that cycle (already registered); the consumer must gate it with its own flush.
- result holds its last value until the next completed operation; it is not cleared on return to IDLE.
- stall_req drops in the DONE cycle so the divide instruction advances while result_valid=1.
- Divide-by-zero results (quotient all-ones, remainder = dividend, no sign fixup) are team-defined because the ISA leaves them undefined.

Test Plan:
- Unsigned 7 / 2: start, signed_div=0 -> stall_req high 33 cycles (E0..E32); result_valid one cycle; result={0x00000001, 0x00000003}.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> result={0xFFFFFFFF, 0xFFFFFFFD}. Repeat 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 0x10 -> {0x0000000F, 0x0FFFFFFF}.
- Divide by zero, 5 / 0 -> result_valid in the cycle after E0; result={0x00000005, 0xFFFFFFFF}; stall_req high only in the start cycle.
- annul at the 10th BUSY cycle -> IDLE next edge, no result_valid, result unchanged. Then start 100 / 7 -> {0x00000002, 0x0000000E}.
- resetn pulsed low mid-BUSY -> outputs 0 immediately, IDLE; start re-held during BUSY with other operands -> ignored, original result delivered.

Source files
------------

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Multi-cycle restoring radix-2 integer divider for the EX stage. It
//   produces one quotient bit per clock and handles DIV (two's complement)
//   and DIVU operations. The result is packed as {HI = remainder,
//   LO = quotient} for the hi/lo register file.
//
// Ports
//   clk           rising-edge clock
//   resetn        asynchronous active-low reset
//   start         request a divide; sampled only in IDLE
//   signed_div    1 = DIV (signed), 0 = DIVU; sampled with start
//   dividend      rs operand; sampled with start
//   divisor       rt operand; sampled with start
//   annul         cancel the current/requested operation (exception flush)
//   stall_req     combinational pipeline hold request
//   result_valid  registered one-cycle pulse when result is ready
//   result        registered {remainder, quotient}
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               annul,
  output logic               stall_req,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_dvd_q;
  logic             sign_dvs_q;

  logic             accept;
  logic             div_by_zero;
  logic             last_iter;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign accept      = start & ~annul;
  assign div_by_zero = (divisor == '0);
  assign last_iter   = (count_q == CW'(WIDTH - 1));

  // Operand conditioning: the iteration works on magnitudes only, and the
  // sign flags are only ever set in signed mode, so DIVU needs no fixup.
  assign dvd_neg = signed_div & dividend[WIDTH-1];
  assign dvs_neg = signed_div & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

  // One restoring step: shift the next dividend bit (held in the MSB of the
  // quotient register) into the partial remainder and trial-subtract. The
  // extra top bit of the difference is the borrow, i.e. a negative result.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~trial[WIDTH];
  assign rem_step  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], q_bit};

  // Sign fixup: the remainder follows the dividend sign. -2^(W-1) / -1
  // naturally yields quotient 0x80..0 because both signs cancel.
  assign quo_fix = (sign_dvd_q ^ sign_dvs_q) ? (~quo_step + 1'b1) : quo_step;
  assign rem_fix = sign_dvd_q ? (~rem_step + 1'b1) : rem_step;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and stall request. The stall drops in DONE so the divide
  // instruction leaves EX in the same cycle result_valid is high.
  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_req  = 1'b1;
          state_next = div_by_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (annul) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. result is only written when an operation completes, so it
  // keeps its last value across IDLE and across an annulled operation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q      <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      sign_dvd_q   <= 1'b0;
      sign_dvs_q   <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sign_dvd_q <= dvd_neg;
            sign_dvs_q <= dvs_neg;
            quo_q      <= dvd_mag;
            dvs_q      <= dvs_mag;
            rem_q      <= '0;
            count_q    <= '0;
            if (div_by_zero) begin
              // Team-defined divide-by-zero result: raw dividend, all-ones
              // quotient, no sign fixup.
              result       <= {dividend, {WIDTH{1'b1}}};
              result_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!annul) begin
            rem_q   <= rem_step;
            quo_q   <= quo_step;
            count_q <= count_q + 1'b1;
            if (last_iter) begin
              result       <= {rem_fix, quo_fix};
              result_valid <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit: a table of directed divides with
//   hand-computed results, plus hand-written sequences for reset, annul and
//   start-while-busy behaviour.
// ---------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;

  logic           clk;
  logic           resetn;
  logic           start;
  logic           signed_div;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           annul;
  logic           stall_req;
  logic           result_valid;
  logic [2*W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .dividend     (dividend),
    .divisor      (divisor),
    .annul        (annul),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           sdiv;
    logic [W-1:0]   dvd;
    logic [W-1:0]   dvs;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check_output(input string name, input logic [2*W-1:0] act,
                              input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Runs one divide from an idle unit. Inputs change on the falling edge;
  // outputs are sampled on the falling edge. lat counts falling edges after
  // the start edge E0 until result_valid; stalls counts cycles with stall_req.
  task automatic apply_stimulus(input logic sdiv, input logic [W-1:0] dvd,
                                input logic [W-1:0] dvs,
                                output logic [2*W-1:0] res, output int lat,
                                output int stalls, output logic got,
                                output logic valid_after);
    res = '0; lat = 0; stalls = 0; got = 1'b0; valid_after = 1'b0;
    @(negedge clk);
    start = 1'b1; signed_div = sdiv; dividend = dvd; divisor = dvs; annul = 1'b0;
    #1;
    if (stall_req) stalls++;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (stall_req) stalls++;
      if (result_valid) begin
        got = 1'b1;
        lat = c;
        res = result;
      end
    end
    @(negedge clk);
    valid_after = result_valid;
  endtask

  logic [2*W-1:0] res;
  logic [2*W-1:0] held;
  int             lat;
  int             stalls;
  logic           got;
  logic           valid_after;
  int             exp_lat;
  int             valid_seen;

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0007, 32'h0000_0002, {32'h0000_0001, 32'h0000_0003}};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF}};
    vecs[5]  = '{1'b0, 32'h0000_0005, 32'h0000_0000, {32'h0000_0005, 32'hFFFF_FFFF}};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003}};
    vecs[7]  = '{1'b0, 32'h0000_0064, 32'h0000_0007, {32'h0000_0002, 32'h0000_000E}};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFB, 32'h0000_0000, {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
    vecs[9]  = '{1'b0, 32'h0000_0003, 32'h0000_0005, {32'h0000_0003, 32'h0000_0000}};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 32'hFFFF_FFFF}};
    vecs[11] = '{1'b1, 32'h0000_0064, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}};
    vecs[12] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}};
    vecs[13] = '{1'b1, 32'h8000_0000, 32'h0000_0001, {32'h0000_0000, 32'h8000_0000}};

    resetn = 1'b0; start = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0; annul = 1'b0;
    #1;
    check_output("reset_result", result, '0);
    check_output("reset_valid", {63'd0, result_valid}, 64'd0);
    check_output("reset_stall", {63'd0, stall_req}, 64'd0);
    #20 resetn = 1'b1;

    // Table-driven directed divides.
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].sdiv, vecs[i].dvd, vecs[i].dvs, res, lat, stalls, got, valid_after);
      exp_lat = (vecs[i].dvs == '0) ? 1 : 33;
      check_output($sformatf("vec%0d_seen", i), {63'd0, got}, 64'd1);
      check_output($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check_output($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
      check_output($sformatf("vec%0d_stalls", i), 64'(stalls), 64'(exp_lat));
      check_output($sformatf("vec%0d_valid_pulse", i), {63'd0, valid_after}, 64'd0);
      check_output($sformatf("vec%0d_result_hold", i), result, vecs[i].exp);
    end

    // start together with annul in IDLE is ignored.
    held = result;
    @(negedge clk);
    start = 1'b1; annul = 1'b1; signed_div = 1'b0; dividend = 32'd9; divisor = 32'd3;
    #1 check_output("annul_idle_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    #1 check_output("annul_idle_state", {63'd0, stall_req}, 64'd0);
    valid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid) valid_seen++;
    end
    check_output("annul_idle_novalid", 64'(valid_seen), 64'd0);

    // annul in the 10th BUSY cycle abandons the operation.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 9; c++) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    check_output("annul_busy_stall", {63'd0, stall_req}, 64'd1);
    @(posedge clk);
    #1 annul = 1'b0;
    @(negedge clk);
    check_output("annul_busy_idle", {63'd0, stall_req}, 64'd0);
    valid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid) valid_seen++;
    end
    check_output("annul_busy_novalid", 64'(valid_seen), 64'd0);
    check_output("annul_busy_result", result, held);

    apply_stimulus(1'b0, 32'd100, 32'd7, res, lat, stalls, got, valid_after);
    check_output("post_annul_result", res, {32'h0000_0002, 32'h0000_000E});
    check_output("post_annul_latency", 64'(lat), 64'd33);

    // Reset pulsed mid-BUSY clears outputs at once and abandons the divide.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 5; c++) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_output("midreset_result", result, '0);
    check_output("midreset_valid", {63'd0, result_valid}, 64'd0);
    check_output("midreset_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    valid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid) valid_seen++;
    end
    check_output("midreset_novalid", 64'(valid_seen), 64'd0);
    check_output("midreset_result_hold", result, '0);

    // start held during BUSY with different operands is ignored.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1 dividend = 32'd9; divisor = 32'd3;
    got = 1'b0; lat = 0; res = '0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1'b1;
        lat = c;
        res = result;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_output("busy_start_seen", {63'd0, got}, 64'd1);
    check_output("busy_start_result", res, {32'h0000_0000, 32'h0000_000A});
    check_output("busy_start_latency", 64'(lat), 64'd33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
